// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    // Transfer phases of the target state machine
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        PTR,
        WR,
        ACK_W,
        RD,
        RACK,
        WAIT
    } state_t;

    // Value of the R/W bit in the address byte
    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer for one I2C bus line: SYNC flops plus a history flop,
// giving the settled level and single-cycle rise/fall strobes.
module i2c_line_sync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC-1:0] chain;
    logic            hist;

    // Shift the raw line through the chain; everything presets to the idle-high bus level
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chain <= '1;
            hist  <= 1'b1;
        end else begin
            chain <= {chain[SYNC-2:0], din};
            hist  <= chain[SYNC-1];
        end
    end

    assign level = chain[SYNC-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8 x 8 register file, auto-incrementing pointer and
// register 0 mirrored onto a parallel port. SDA is pulled open-drain;
// SCL is only observed.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR     = 7'h27,
    parameter int         SYNC     = 2,
    parameter logic [7:0] RST_PORT = 8'h00
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_pull,
    output logic [7:0] port_out,
    output logic       busy,
    output logic       wr_stb,
    output logic [2:0] wr_idx,
    output logic [7:0] wr_data
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC(SYNC)) u_scl (
        .clk  (clk),
        .nrst (nrst),
        .din  (scl),
        .level(scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_line_sync #(.SYNC(SYNC)) u_sda (
        .clk  (clk),
        .nrst (nrst),
        .din  (sda),
        .level(sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    // Bus conditions: SDA moving while SCL is high
    logic start, stop;
    assign start = sda_fall & scl_lvl;
    assign stop  = sda_rise & scl_lvl;

    state_t     state, state_n, after, after_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic [2:0] ptr, ptr_n;
    logic       pull_n, busy_n, we;
    logic [7:0] regs [8];
    logic [7:0] byte_in;

    // Byte completed by the bit being sampled on this SCL rise
    assign byte_in  = {sh[6:0], sda_lvl};
    assign port_out = regs[0];

    // State, shift/count registers and write-strobe outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            after    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            ptr      <= '0;
            sda_pull <= 1'b0;
            busy     <= 1'b0;
            wr_stb   <= 1'b0;
            wr_idx   <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            after    <= after_n;
            cnt      <= cnt_n;
            sh       <= sh_n;
            ptr      <= ptr_n;
            sda_pull <= pull_n;
            busy     <= busy_n;
            wr_stb   <= we;
            if (we) begin
                wr_idx  <= ptr;
                wr_data <= byte_in;
            end
        end
    end

    // Register file; entry 0 resets to the port default
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= (i == 0) ? RST_PORT : 8'h00;
            end
        end else if (we) begin
            regs[ptr] <= byte_in;
        end
    end

    // Next-state logic; START/STOP take priority over any SCL edge in the same cycle
    always_comb begin
        state_n = state;
        after_n = after;
        cnt_n   = cnt;
        sh_n    = sh;
        ptr_n   = ptr;
        pull_n  = sda_pull;
        busy_n  = busy;
        we      = 1'b0;
        if (start) begin
            state_n = i2c_pkg::ADDR;
            cnt_n   = '0;
            busy_n  = 1'b1;
        end else if (stop) begin
            state_n = IDLE;
            pull_n  = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                i2c_pkg::ADDR: begin
                    // A pull left over from before a repeated START is dropped here
                    if (scl_fall) pull_n = 1'b0;
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n = '0;
                            if (byte_in[7:1] == ADDR) begin
                                state_n = ACK_A;
                                after_n = (byte_in[0] == I2C_RD) ? RD : PTR;
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end
                end
                ACK_A, ACK_W: begin
                    // First fall asserts the ACK, second fall ends it
                    if (scl_fall) begin
                        if (!sda_pull) begin
                            pull_n = 1'b1;
                        end else begin
                            pull_n  = 1'b0;
                            state_n = after;
                            if (after == RD) begin
                                // The MSB of the read byte goes out on this same fall
                                pull_n = ~regs[ptr][7];
                                sh_n   = {regs[ptr][6:0], 1'b0};
                                cnt_n  = 4'd1;
                            end
                        end
                    end
                end
                PTR, WR: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n   = '0;
                            state_n = ACK_W;
                            after_n = WR;
                            if (state == PTR) begin
                                ptr_n = byte_in[2:0];
                            end else begin
                                we    = 1'b1;
                                ptr_n = ptr + 3'd1;
                            end
                        end
                    end
                end
                RD: begin
                    if (scl_fall) begin
                        if (cnt < 4'd8) begin
                            pull_n = ~sh[7];
                            sh_n   = {sh[6:0], 1'b0};
                            cnt_n  = cnt + 4'd1;
                        end else begin
                            pull_n  = 1'b0;
                            state_n = RACK;
                            ptr_n   = ptr + 3'd1;
                            cnt_n   = '0;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_n = WAIT;
                        end else begin
                            state_n = RD;
                            sh_n    = regs[ptr];
                            cnt_n   = '0;
                        end
                    end
                end
                WAIT: pull_n = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: table of single-transaction writes plus
// hand-written sequences for wrap, repeated-START read, abort, latency and reset.
module tb_i2c_target;

    localparam logic [7:0] RST_PORT = 8'h00;
    localparam int         H        = 4;
    localparam int         Q        = 8;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_pull;
    logic [7:0] port_out;
    logic       busy;
    logic       wr_stb;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;

    int errors = 0;
    int checks = 0;
    int pull_cyc = 0;
    logic [10:0] stb_log [$];

    assign sda_bus = sda_drv & ~sda_pull;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(7'h27), .SYNC(2), .RST_PORT(RST_PORT)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .scl     (scl),
        .sda     (sda_bus),
        .sda_pull(sda_pull),
        .port_out(port_out),
        .busy    (busy),
        .wr_stb  (wr_stb),
        .wr_idx  (wr_idx),
        .wr_data (wr_data)
    );

    // Log every write strobe and count cycles the target pulls SDA
    always @(negedge clk) begin
        if (wr_stb) stb_log.push_back({wr_idx, wr_data});
        if (sda_pull) pull_cyc <= pull_cyc + 1;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [2:0] exp_ack;   // {addr, b1, b2}; 0 = acknowledged
        int         exp_nstb;
        logic [2:0] exp_idx;
        logic [7:0] exp_data;
        logic [7:0] exp_port;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        clks(H); sda_drv = b; clks(H); scl = 1'b1; clks(Q); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        clks(H); sda_drv = 1'b1; clks(H); scl = 1'b1; clks(H); b = sda_bus; clks(H); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic do_start;
        clks(Q); sda_drv = 1'b0; clks(Q); scl = 1'b0;
    endtask

    task automatic do_rstart;
        clks(H); sda_drv = 1'b1; clks(H); scl = 1'b1; clks(Q); sda_drv = 1'b0; clks(Q); scl = 1'b0;
    endtask

    task automatic do_stop;
        clks(H); sda_drv = 1'b0; clks(H); scl = 1'b1; clks(Q); sda_drv = 1'b1; clks(Q);
    endtask

    initial begin
        logic       k0, k1, k2;
        logic [7:0] rd, bt;
        int         s0, p0;

        vecs[0] = '{8'h4E, 8'h00, 8'hA5, 3'b000, 1, 3'd0, 8'hA5, 8'hA5};
        vecs[1] = '{8'h4E, 8'h03, 8'h5A, 3'b000, 1, 3'd3, 8'h5A, 8'hA5};
        vecs[2] = '{8'h40, 8'hFF, 8'hFF, 3'b111, 0, 3'd0, 8'h00, 8'hA5};
        vecs[3] = '{8'h4E, 8'hF8, 8'hC3, 3'b000, 1, 3'd0, 8'hC3, 8'hC3};
        vecs[4] = '{8'h4C, 8'h00, 8'h77, 3'b111, 0, 3'd0, 8'h00, 8'hC3};
        vecs[5] = '{8'h4E, 8'h00, 8'hA5, 3'b000, 1, 3'd0, 8'hA5, 8'hA5};

        // Reset state
        clks(3);
        check("rst sda_pull", sda_pull, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst wr_stb", wr_stb, 1'b0);
        check("rst wr_idx", wr_idx, 3'd0);
        check("rst wr_data", wr_data, 8'h00);
        check("rst port_out", port_out, RST_PORT);
        nrst = 1'b1;
        clks(5);

        // Table of single write transactions
        for (int r = 0; r < 6; r++) begin
            s0 = stb_log.size();
            p0 = pull_cyc;
            do_start;
            write_byte(vecs[r].a, k0);
            write_byte(vecs[r].b1, k1);
            write_byte(vecs[r].b2, k2);
            check($sformatf("row%0d busy_mid", r), busy, 1'b1);
            do_stop;
            check($sformatf("row%0d acks", r), {k0, k1, k2}, vecs[r].exp_ack);
            check($sformatf("row%0d busy_end", r), busy, 1'b0);
            check($sformatf("row%0d nstb", r), stb_log.size() - s0, vecs[r].exp_nstb);
            if (vecs[r].exp_nstb > 0 && stb_log.size() > s0)
                check($sformatf("row%0d stb", r), stb_log[s0], {vecs[r].exp_idx, vecs[r].exp_data});
            check($sformatf("row%0d port", r), port_out, vecs[r].exp_port);
            if (vecs[r].exp_ack == 3'b111)
                check($sformatf("row%0d pull_cycles", r), pull_cyc - p0, 0);
        end

        // Latency: ACK pull and write strobe land SYNC+1 clocks after the SCL edge
        s0 = stb_log.size();
        bt = 8'h4E;
        do_start;
        for (int i = 7; i >= 1; i--) send_bit(bt[i]);
        clks(H); sda_drv = bt[0]; clks(H); scl = 1'b1; clks(Q); scl = 1'b0;
        clks(1); check("lat ack c1", sda_pull, 1'b0);
        clks(1); check("lat ack c2", sda_pull, 1'b0);
        clks(1); check("lat ack c3", sda_pull, 1'b1);
        recv_bit(k0);
        check("lat addr ack", k0, 1'b0);
        write_byte(8'h02, k1);
        check("lat ptr ack", k1, 1'b0);
        bt = 8'h77;
        for (int i = 7; i >= 1; i--) send_bit(bt[i]);
        clks(H); sda_drv = bt[0]; clks(H); scl = 1'b1;
        clks(1); check("lat stb c1", wr_stb, 1'b0);
        clks(1); check("lat stb c2", wr_stb, 1'b0);
        clks(1); check("lat stb c3", wr_stb, 1'b1);
        check("lat stb idx/data", {wr_idx, wr_data}, {3'd2, 8'h77});
        clks(1); check("lat stb width", wr_stb, 1'b0);
        clks(Q - 4); scl = 1'b0;
        recv_bit(k2);
        check("lat data ack", k2, 1'b0);
        do_stop;
        check("lat nstb", stb_log.size() - s0, 1);

        // Auto-increment across the 7 -> 0 wrap
        s0 = stb_log.size();
        do_start;
        write_byte(8'h4E, k0);
        write_byte(8'h07, k1);
        write_byte(8'h11, k2);
        check("wrap ack1", {k0, k1, k2}, 3'b000);
        write_byte(8'h22, k2);
        check("wrap ack2", k2, 1'b0);
        do_stop;
        check("wrap nstb", stb_log.size() - s0, 2);
        if (stb_log.size() >= s0 + 2) begin
            check("wrap stb0", stb_log[s0], {3'd7, 8'h11});
            check("wrap stb1", stb_log[s0+1], {3'd0, 8'h22});
        end
        check("wrap port", port_out, 8'h22);

        // Repeated-START read of reg[7], reg[0]
        s0 = stb_log.size();
        do_start;
        write_byte(8'h4E, k0);
        write_byte(8'h07, k1);
        do_rstart;
        write_byte(8'h4F, k2);
        check("rd acks", {k0, k1, k2}, 3'b000);
        read_byte(rd, 1'b0);
        check("rd byte0", rd, 8'h11);
        read_byte(rd, 1'b1);
        check("rd byte1", rd, 8'h22);
        check("rd released", sda_pull, 1'b0);
        p0 = pull_cyc;
        clks(2 * Q);
        check("rd wait no pull", pull_cyc - p0, 0);
        do_stop;
        check("rd busy_end", busy, 1'b0);
        check("rd nstb", stb_log.size() - s0, 0);

        // Abort mid-byte, then a clean write to idx 1
        s0 = stb_log.size();
        do_start;
        write_byte(8'h4E, k0);
        write_byte(8'h01, k1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        do_stop;
        check("abort nstb", stb_log.size() - s0, 0);
        check("abort busy", busy, 1'b0);
        do_start;
        write_byte(8'h4E, k0);
        write_byte(8'h01, k1);
        write_byte(8'h3C, k2);
        do_stop;
        check("post-abort acks", {k0, k1, k2}, 3'b000);
        check("post-abort nstb", stb_log.size() - s0, 1);
        if (stb_log.size() > s0)
            check("post-abort stb", stb_log[s0], {3'd1, 8'h3C});

        // Read back idx 1 and 2
        do_start;
        write_byte(8'h4E, k0);
        write_byte(8'h01, k1);
        do_rstart;
        write_byte(8'h4F, k2);
        read_byte(rd, 1'b0);
        check("rb reg1", rd, 8'h3C);
        read_byte(rd, 1'b1);
        check("rb reg2", rd, 8'h77);
        do_stop;

        // Reset while the target drives a 0 read bit
        do_start;
        write_byte(8'h4E, k0);
        write_byte(8'h00, k1);
        do_rstart;
        write_byte(8'h4F, k2);
        clks(4);
        check("rst_mid pre pull", sda_pull, 1'b1);
        #2 nrst = 1'b0;
        #1;
        check("rst_mid sda_pull", sda_pull, 1'b0);
        check("rst_mid port", port_out, RST_PORT);
        check("rst_mid busy", busy, 1'b0);
        check("rst_mid wr_idx", wr_idx, 3'd0);
        check("rst_mid wr_data", wr_data, 8'h00);
        clks(2);
        scl = 1'b1;
        sda_drv = 1'b1;
        clks(3);
        nrst = 1'b1;
        clks(5);
        check("post-rst port", port_out, RST_PORT);
        check("post-rst busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
